// File: rtl/game_pkg.sv
// Shared game definitions: floor/score limits, slot record, scheduler
// FSM states and the top-level game state codes.
package game_pkg;

   localparam logic [9:0] LOWER_BOUND = 10'd480;  // y at/after which a glyph hits the floor
   localparam logic [7:0] SCORE_MAX   = 8'd99;    // two-digit score display limit

   // Top-level game state codes (owned by the top-level FSM, shared here)
   typedef enum logic [1:0] {
      WEL_STATE  = 2'd0,
      PLAY_STATE = 2'd1,
      END_STATE  = 2'd2
   } game_state_e;

   // Slot scheduler FSM
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MOVE   = 2'd1,
      S_MATCH  = 2'd2,
      S_REMOVE = 2'd3
   } sched_state_e;

   // One falling glyph
   typedef struct packed {
      logic       active;
      logic [7:0] ascii;
      logic [9:0] col;
      logic [9:0] y;
      logic [2:0] speed;
   } slot_t;

   // Score increment that sticks at SCORE_MAX
   function automatic logic [7:0] sat_inc(input logic [7:0] s);
      return (s >= SCORE_MAX) ? SCORE_MAX : s + 8'd1;
   endfunction

endpackage

// File: rtl/slot_alloc.sv
// Lowest-index free slot finder with a table-full flag.
module slot_alloc #(
   parameter int NSLOT = 16,
   parameter int IDX_W = 4
) (
   input  logic [NSLOT-1:0] active_i,
   output logic [IDX_W-1:0] free_idx_o,
   output logic             full_o
);

   // Scan from the top down so the lowest free index wins
   always_comb begin
      free_idx_o = '0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (!active_i[i]) free_idx_o = IDX_W'(i);
      end
   end

   assign full_o = &active_i;

endmodule

// File: rtl/char_slot_scheduler.sv
// Falling-character slot table: spawns glyphs, moves them once per frame,
// removes the lowest glyph matching a key, keeps score and gameover.
module char_slot_scheduler
   import game_pkg::*;
#(
   parameter int NSLOT = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             clear,
   input  logic             frame_tick,
   input  logic             spawn_valid,
   output logic             spawn_ready,
   input  logic [7:0]       spawn_ascii,
   input  logic [9:0]       spawn_col,
   input  logic [9:0]       spawn_y,
   input  logic [2:0]       spawn_speed,
   input  logic             key_valid,
   input  logic [7:0]       key_ascii,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_active,
   output logic [7:0]       rd_ascii,
   output logic [9:0]       rd_col,
   output logic [9:0]       rd_y,
   output logic [7:0]       score,
   output logic             hit_pulse,
   output logic             miss_pulse,
   output logic             gameover,
   output logic [IDX_W:0]   active_count,
   output logic             busy
);

   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLOT - 1);
   localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

   slot_t            slots_q [NSLOT];
   slot_t            slots_d [NSLOT];
   sched_state_e     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             tick_pend_q, tick_pend_d;
   logic             key_pend_q, key_pend_d;
   logic [7:0]       key_asc_q, key_asc_d;
   logic [7:0]       cur_key_q, cur_key_d;
   logic             best_found_q, best_found_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic [9:0]       best_y_q, best_y_d;
   logic [7:0]       score_q, score_d;
   logic             gameover_q, gameover_d;
   logic             hit_q, hit_d;
   logic             miss_q, miss_d;
   logic [IDX_W:0]   cnt_q, cnt_d;

   logic [NSLOT-1:0] active_vec;
   logic [IDX_W-1:0] free_idx;
   logic             full;
   logic             run;
   logic [10:0]      y_new;

   // Gather occupancy bits for the allocator
   always_comb begin
      for (int i = 0; i < NSLOT; i++) active_vec[i] = slots_q[i].active;
   end

   slot_alloc #(
      .NSLOT (NSLOT),
      .IDX_W (IDX_W)
   ) u_alloc (
      .active_i   (active_vec),
      .free_idx_o (free_idx),
      .full_o     (full)
   );

   // The table only evolves while playing and before the floor is hit
   assign run = enable && !gameover_q;

   assign spawn_ready = (state_q == S_IDLE) && run && !full && !tick_pend_q && !key_pend_q
                        && !frame_tick && !key_valid && !clear;

   // Next-state logic: event dispatch, slot scan, spawn write
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
      slots_d      = slots_q;
      state_d      = state_q;
      idx_d        = idx_q;
      tick_pend_d  = tick_pend_q;
      key_pend_d   = key_pend_q;
      key_asc_d    = key_asc_q;
      cur_key_d    = cur_key_q;
      best_found_d = best_found_q;
      best_idx_d   = best_idx_q;
      best_y_d     = best_y_q;
      score_d      = score_q;
      gameover_d   = gameover_q;
      cnt_d        = cnt_q;
      hit_d        = 1'b0;
      miss_d       = 1'b0;
      y_new        = '0;

      if (clear) begin
         for (int i = 0; i < NSLOT; i++) slots_d[i] = '0;
         state_d      = S_IDLE;
         idx_d        = '0;
         tick_pend_d  = 1'b0;
         key_pend_d   = 1'b0;
         key_asc_d    = '0;
         cur_key_d    = '0;
         best_found_d = 1'b0;
         best_idx_d   = '0;
         best_y_d     = '0;
         score_d      = '0;
         gameover_d   = 1'b0;
         cnt_d        = '0;
      end else if (!run) begin
         // Frozen: abandon any scan in flight, touch nothing in the table
         state_d = S_IDLE;
         idx_d   = '0;
      end else begin
         // Events arriving mid-scan are parked (one deep each)
         if (state_q != S_IDLE) begin
            if (frame_tick) tick_pend_d = 1'b1;
            if (key_valid && !key_pend_q) begin
               key_pend_d = 1'b1;
               key_asc_d  = key_ascii;
            end
         end

         unique case (state_q)
            S_IDLE: begin
               if (tick_pend_q || frame_tick) begin
                  state_d     = S_MOVE;
                  idx_d       = '0;
                  tick_pend_d = 1'b0;
                  if (key_valid && !key_pend_q) begin
                     key_pend_d = 1'b1;
                     key_asc_d  = key_ascii;
                  end
               end else if (key_pend_q || key_valid) begin
                  state_d      = S_MATCH;
                  idx_d        = '0;
                  best_found_d = 1'b0;
                  best_idx_d   = '0;
                  best_y_d     = '0;
                  cur_key_d    = key_pend_q ? key_asc_q : key_ascii;
                  // A fresh key arriving as the parked one is consumed takes its place
                  key_pend_d   = key_pend_q && key_valid;
                  if (key_pend_q && key_valid) key_asc_d = key_ascii;
               end else if (spawn_valid && spawn_ready) begin
                  slots_d[free_idx] = '{active: 1'b1, ascii: spawn_ascii, col: spawn_col,
                                        y: spawn_y, speed: spawn_speed};
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            S_MOVE: begin
               if (slots_q[idx_q].active) begin
                  y_new = {1'b0, slots_q[idx_q].y} + {8'b0, slots_q[idx_q].speed};
                  if (y_new >= {1'b0, LOWER_BOUND}) begin
                     slots_d[idx_q] = '0;
                     gameover_d     = 1'b1;
                     cnt_d          = cnt_q - CNT_ONE;
                  end else begin
                     slots_d[idx_q].y = y_new[9:0];
                  end
               end
               idx_d = idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) state_d = S_IDLE;
            end

            S_MATCH: begin
               // Strictly-greater keeps the lowest index on equal heights
               if (slots_q[idx_q].active && (slots_q[idx_q].ascii == cur_key_q)
                   && (!best_found_q || (slots_q[idx_q].y > best_y_q))) begin
                  best_found_d = 1'b1;
                  best_idx_d   = idx_q;
                  best_y_d     = slots_q[idx_q].y;
               end
               idx_d = idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) state_d = S_REMOVE;
            end

            S_REMOVE: begin
               if (best_found_q) begin
                  slots_d[best_idx_q] = '0;
                  score_d             = sat_inc(score_q);
                  hit_d               = 1'b1;
                  cnt_d               = cnt_q - CNT_ONE;
               end else begin
                  miss_d = 1'b1;
               end
               idx_d   = '0;
               state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   // State registers, including the slot table
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the slot table is a flop array, not a RAM, so it is safe (and required) to reset it.
         for (int i = 0; i < NSLOT; i++) slots_q[i] <= '0;
         state_q      <= S_IDLE;
         idx_q        <= '0;
         tick_pend_q  <= 1'b0;
         key_pend_q   <= 1'b0;
         key_asc_q    <= '0;
         cur_key_q    <= '0;
         best_found_q <= 1'b0;
         best_idx_q   <= '0;
         best_y_q     <= '0;
         score_q      <= '0;
         gameover_q   <= 1'b0;
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         for (int i = 0; i < NSLOT; i++) slots_q[i] <= slots_d[i];
         state_q      <= state_d;
         idx_q        <= idx_d;
         tick_pend_q  <= tick_pend_d;
         key_pend_q   <= key_pend_d;
         key_asc_q    <= key_asc_d;
         cur_key_q    <= cur_key_d;
         best_found_q <= best_found_d;
         best_idx_q   <= best_idx_d;
         best_y_q     <= best_y_d;
         score_q      <= score_d;
         gameover_q   <= gameover_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         cnt_q        <= cnt_d;
      end
   end

   assign rd_active    = slots_q[rd_idx].active;
   assign rd_ascii     = slots_q[rd_idx].ascii;
   assign rd_col       = slots_q[rd_idx].col;
   assign rd_y         = slots_q[rd_idx].y;
   assign score        = score_q;
   assign hit_pulse    = hit_q;
   assign miss_pulse   = miss_q;
   assign gameover     = gameover_q;
   assign active_count = cnt_q;
   assign busy         = (state_q != S_IDLE);

endmodule
